// File: rtl/filter_pkg.sv
// rtl/filter_pkg.sv - shared lane types and sample widening for the polyphase IIR datapath
package filter_pkg;

  localparam int LANES    = 3;
  localparam int IN_W     = 11;
  localparam int LANE_W   = 36;
  localparam int FRAC_LSB = 24;

  typedef logic signed [LANE_W-1:0] lane_t;
  typedef lane_t frame_t [0:LANES-1];

  // Sign-extend the sample into the lane and place its LSB at FRAC_LSB; exact, no rounding.
  function automatic lane_t widen(input logic signed [IN_W-1:0] sample);
    lane_t ext;
    ext = lane_t'(sample);
    return ext <<< FRAC_LSB;
  endfunction

endpackage

// File: rtl/in_demux_fast.sv
// rtl/in_demux_fast.sv - fast-clock phase counter, shadow lanes and frame register
module in_demux_fast
  import filter_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic signed [IN_W-1:0] sample,
  output frame_t                 frame
);

  logic [1:0] cnt;
  logic [1:0] cnt_next;
  lane_t      lane;
  lane_t      shadow [0:LANES-1];

  assign lane = widen(sample);

  // Phase walks 0 -> 2 -> 1 -> 0; the stray value 3 recovers into the sequence at 2.
  always_comb begin
    cnt_next = 2'd2;
    case (cnt)
      2'd0:    cnt_next = 2'd2;
      2'd1:    cnt_next = 2'd0;
      2'd2:    cnt_next = 2'd1;
      default: cnt_next = 2'd2;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 2'd0;
      for (int i = 0; i < LANES; i++) begin
        shadow[i] <= '0;
        frame[i]  <= '0;
      end
    end else begin
      cnt <= cnt_next;
      if (cnt != 2'd3) begin
        shadow[cnt] <= lane;
      end
      // Frame loads one fast cycle before the slow capture edge and then holds for 3 cycles.
      if (cnt == 2'd1) begin
        frame[0] <= shadow[0];
        frame[2] <= shadow[2];
        frame[1] <= lane;
      end
    end
  end

endmodule

// File: rtl/in_demux.sv
// rtl/in_demux.sv - input demultiplexer/downsampler feeding the three polyphase branches
module in_demux
  import filter_pkg::*;
(
  input  logic                   clk_div_3,
  input  logic                   reset,
  input  logic                   clk,
  input  logic signed [IN_W-1:0] In,
  output frame_t                 Out,
  output logic                   Out_valid
);

  frame_t     frame;
  frame_t     stage1;
  frame_t     stage2;
  logic [1:0] vcnt;

  in_demux_fast u_fast (
    .clk    (clk),
    .reset  (reset),
    .sample (In),
    .frame  (frame)
  );

  // Frame register is stable across every slow edge, so it is captured directly.
  always_ff @(posedge clk_div_3) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) begin
        stage1[i] <= '0;
        stage2[i] <= '0;
      end
      vcnt      <= 2'd0;
      Out_valid <= 1'b0;
    end else begin
      stage1 <= frame;
      stage2 <= stage1;
      if (vcnt < 2'd2) begin
        vcnt <= vcnt + 2'd1;
      end
      // Registered so the flag rises on the same slow edge as the first real frame at Out.
      Out_valid <= (vcnt == 2'd2);
    end
  end

  assign Out = stage2;

endmodule

// File: tb/tb_in_demux.sv
// tb/tb_in_demux.sv - directed, table-driven bench for in_demux
module tb_in_demux;
  import filter_pkg::*;

  typedef struct {
    logic signed [10:0] s0;
    logic signed [10:0] s1;
    logic signed [10:0] s2;
    lane_t              e0;
    lane_t              e1;
    lane_t              e2;
  } vec_t;

  localparam int NT = 4;
  localparam int NK = 3 * NT + 300 + 6;

  logic               clk       = 1'b0;
  logic               clk_div_3 = 1'b0;
  logic               reset     = 1'b1;
  logic signed [10:0] In        = '0;
  frame_t             Out;
  logic               Out_valid;

  int n_tests = 0;
  int n_fail  = 0;

  vec_t               tbl  [0:NT-1];
  logic signed [10:0] hist [0:NK-1];

  in_demux dut (
    .clk_div_3 (clk_div_3),
    .reset     (reset),
    .clk       (clk),
    .In        (In),
    .Out       (Out),
    .Out_valid (Out_valid)
  );

  always #3 clk = ~clk;
  always #9 clk_div_3 = ~clk_div_3;

  function automatic lane_t w(input logic signed [10:0] v);
    return {v[10], v, 24'b0};
  endfunction

  task automatic chk_lane(input string name, input lane_t act, input lane_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input lane_t e0, input lane_t e1, input lane_t e2,
                         input logic ev);
    chk_lane({tag, " lane0"}, Out[0], e0);
    chk_lane({tag, " lane1"}, Out[1], e1);
    chk_lane({tag, " lane2"}, Out[2], e2);
    chk_bit({tag, " valid"}, Out_valid, ev);
  endtask

  task automatic step(input logic signed [10:0] v);
    In = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic signed [10:0] s, r;
    lane_t l;

    tbl[0] = '{11'sh001, 11'sh002, 11'sh003, 36'sh001000000, 36'sh003000000, 36'sh002000000};
    tbl[1] = '{11'sh7FF, 11'sh400, 11'sh3FF, 36'shFFF000000, 36'sh3FF000000, 36'shC00000000};
    tbl[2] = '{11'sh155, 11'sh2AA, 11'sh400, 36'sh155000000, 36'shC00000000, 36'sh2AA000000};
    tbl[3] = '{11'sh000, 11'sh001, 11'sh7FE, 36'sh000000000, 36'shFFE000000, 36'sh001000000};
    for (int k = 0; k < NK; k++) begin
      if (k < 3 * NT) begin
        case (k % 3)
          0:       hist[k] = tbl[k / 3].s0;
          1:       hist[k] = tbl[k / 3].s1;
          default: hist[k] = tbl[k / 3].s2;
        endcase
      end else if (k < 3 * NT + 300) begin
        hist[k] = 11'(k - 3 * NT);
      end else begin
        hist[k] = '0;
      end
    end

    // Reset held well past one slow edge; release lands just before a slow edge.
    reset = 1'b1;
    In    = 11'sh7FF;
    @(posedge clk_div_3);
    #1;
    chk_out("reset slow", '0, '0, '0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(11'sh7FF);
      chk_out($sformatf("reset c%0d", i), '0, '0, '0, 1'b0);
    end
    reset = 1'b0;

    // Table frames followed by a ramp; Out must trail each frame by 6 fast edges.
    for (int k = 0; k < NK; k++) begin
      step(hist[k]);
      if (k < 6) begin
        chk_out($sformatf("k%0d", k), '0, '0, '0, 1'b0);
      end else begin
        n = (k - 6) / 3;
        if (n < NT) begin
          chk_out($sformatf("tbl%0d k%0d", n, k), tbl[n].e0, tbl[n].e1, tbl[n].e2, 1'b1);
        end else begin
          chk_out($sformatf("ramp f%0d k%0d", n, k),
                  w(hist[3 * n]), w(hist[3 * n + 2]), w(hist[3 * n + 1]), 1'b1);
        end
      end
    end

    // Realign with a short reset, then reset again mid-frame at k=7.
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step(11'sh000);
    reset = 1'b0;
    for (int k = 0; k < 7; k++) step(11'(100 + k));
    chk_out("pre-mid k6", w(11'sd100), w(11'sd102), w(11'sd101), 1'b1);
    reset = 1'b1;
    step(11'sh0C8);
    step(11'sh0C8);
    step(11'sh0C8);
    chk_out("mid k9", '0, '0, '0, 1'b0);
    step(11'sh0C8);
    chk_out("mid k10", '0, '0, '0, 1'b0);
    step(11'sh0C8);
    chk_out("mid k11", '0, '0, '0, 1'b0);
    reset = 1'b0;
    for (int k = 0; k < 9; k++) begin
      step(11'(50 + k));
      if (k < 6) begin
        chk_out($sformatf("post k%0d", k), '0, '0, '0, 1'b0);
      end else begin
        chk_out($sformatf("post k%0d", k), w(11'sd50), w(11'sd52), w(11'sd51), 1'b1);
      end
    end

    // Round trip through the package widening.
    for (int i = 0; i < 1000; i++) begin
      s = 11'($urandom);
      l = widen(s);
      r = l[34:24] + 11'(l[23]);
      chk_lane($sformatf("widen %h", s), l, w(s));
      n_tests++;
      if (r !== s) begin
        n_fail++;
        $display("FAIL roundtrip: got %h want %h", r, s);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
